jk_sr_counter: RTL
==================

Name: jk_sr_counter

Overview:
- Parameterised synchronous up/down counter whose every state bit is a JK flip-flop built from an SR flip-flop. This is the reverse conversion of the SR-from-JK flip-flop.
- Per bit: S = J & ~Q, R = K & Q, so S and R are never both 1. This makes the JK toggle case legal on an SR core.
- Sits in the flip-flop conversion family as the first multi-bit consumer of a converted flip-flop. Provides load, enable, direction, terminal count and wrap indication.

Parameters:
- WIDTH, 4, counter width in bits; legal values 2 to 16.
- INIT, 0, value loaded into q on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; rst=0 forces reset immediately, independent of clk
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load; has priority over en
- d  input  WIDTH  load value
- q  output  WIDTH  counter state; bit i is the Q of JK cell i
- tc  output  1  combinational terminal count: en & ~load & (up ? q=={WIDTH{1}} : q==0)
- wrap  output  1  registered one-cycle pulse, asserted in the cycle after the counter wraps

Behaviour:
- Reset (rst=0, asynchronous): q=INIT, wrap=0, and tc follows its equation. Reset held across edges keeps q=INIT. Deassertion of rst is synchronous to the design; the first count happens at the first rising edge with rst=1.
- JK cell at a rising edge: J/K = 00 holds, 01 clears, 10 sets, 11 toggles. Internal SR: S=J&~Q, R=K&Q. The SR core never sees S=R=1.
- Load (load=1): J_i=d_i, K_i=~d_i, so q=d after one edge. en and up are ignored that cycle. wrap=0 on the next cycle.
- Count (load=0, en=1):
  - Up: T_i = &q[i-1:0]; T_0 = 1.
  - Down: T_i = &(~q[i-1:0]); T_0 = 1.
  - J_i = K_i = T_i. q changes by ±1 modulo 2^WIDTH with a latency of one edge.
- Idle (load=0, en=0): J=K=0 on all bits; q holds; wrap=0 on the next cycle.
- Wrap: if tc=1 at an edge, q becomes 0 (up) or all ones (down), and wrap=1 for exactly the next cycle.
- Consecutive wraps are possible when WIDTH counts repeat; wrap reasserts each time.
- Direction change mid-count takes effect at the next edge, with no extra latency.
- Load and tc in the same cycle: load wins and no wrap is produced. tc is already 0 in that cycle by its equation.
- Reset asserted mid-count: q goes to INIT and wrap goes to 0 immediately, without waiting for clk.

Optional Feature:
- Macro: JK_SR_COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping.
  - At q=all ones with up=1, or q=0 with up=0, all J=K=0, so q holds.
  - wrap is never asserted.
  - tc still flags the limit.
  - load is unaffected.
- Undefined: modulo wrap as described in Behaviour.

Decomposition:
- Shared package/include ff_conv_pkg:
  - JK code constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - SR code constants: SR_HOLD, SR_RESET, SR_SET, SR_ILLEGAL.
- Sub-module jk_using_sr:
  - One bit: JK-to-SR excitation logic plus the SR storage element.
  - Ports: clk, rst, j, k, init_val, q.
  - Instantiated WIDTH times via generate.
- Top level: toggle-chain logic, load muxing, tc, wrap register.
- Simulation-only check in jk_using_sr: error message if S and R are both 1 at a clock edge.

Test Plan (WIDTH=4, INIT=0):
- Reset: rst=0 for 2 edges with en=1 → q=0000, wrap=0. Release rst, en=1, up=1 for 3 edges → q=0011.
- Up wrap: load d=1110, then en=1, up=1 → q=1111 with tc=1, then q=0000. wrap=1 for exactly one cycle.
  - With SATURATE_EN defined: q stays 1111 and wrap=0.
- Down wrap: load d=0001, up=0, en=1 → q=0000 with tc=1, then q=1111 and wrap pulses.
- Load priority: at q=1111 with up=1 and tc condition met, set load=1, d=0101 → q=0101, wrap=0, tc=0 that cycle.
- Hold and direction: en=0 for 3 edges → q unchanged. Then up toggles 1→0 between edges → count sequence 0101, 0110, 0101.
- Async reset mid-count: drive rst=0 between clock edges at q=1010 → q=0000 before the next edge, and no SR-illegal message ever printed.

Source files
------------

// File: rtl/ff_conv_pkg.sv
// Shared flip-flop conversion codes: JK excitation pairs {J,K} and SR pairs {S,R}.
package ff_conv_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_code_t;

   typedef enum logic [1:0] {
      SR_HOLD    = 2'b00,
      SR_RESET   = 2'b01,
      SR_SET     = 2'b10,
      SR_ILLEGAL = 2'b11
   } sr_code_t;

endpackage

// File: rtl/jk_using_sr.sv
// One JK flip-flop cell built on an SR storage element; S = J & ~Q and R = K & Q
// can never both be 1, which makes the JK toggle case legal on the SR core.
module jk_using_sr
   import ff_conv_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   input  logic init_val,
   output logic q
);

   logic     s;
   logic     r;
   sr_code_t sr;

   assign s  = j & ~q;
   assign r  = k & q;
   assign sr = sr_code_t'({s, r});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= init_val;
      end else begin
         case (sr)
            SR_SET:   q <= 1'b1;
            SR_RESET: q <= 1'b0;
            default:  q <= q;
         endcase
      end
   end

   // Simulation-only guard on the SR core inputs.
   a_sr_legal : assert property (@(posedge clk) disable iff (!rst) sr != SR_ILLEGAL)
      else $error("jk_using_sr: SR illegal, S=R=1 at clock edge");

endmodule

// File: rtl/jk_sr_counter.sv
// Up/down counter whose state bits are JK cells built from SR flip-flops.
// Define JK_SR_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module jk_sr_counter
   import ff_conv_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             at_limit;
   logic             count;
   jk_code_t         jk [WIDTH];

   assign at_limit = up ? (&q) : ~(|q);
   assign tc       = en & ~load & at_limit;

`ifdef JK_SR_COUNTER_SATURATE_EN
   assign count = en & ~at_limit;
`else
   assign count = en;
`endif

   // Ripple toggle chain: a bit toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      t    = '0;
      t[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         t[i] = t[i-1] & (up ? q[i-1] : ~q[i-1]);
      end
   end

   always_comb begin
      j = '0;
      k = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         jk[i] = JK_HOLD;
         if (load) begin
            jk[i] = d[i] ? JK_SET : JK_RESET;
         end else if (count) begin
            jk[i] = t[i] ? JK_TOGGLE : JK_HOLD;
         end
         j[i] = jk[i][1];
         k[i] = jk[i][0];
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_using_sr u_cell (
         .clk      (clk),
         .rst      (rst),
         .j        (j[g]),
         .k        (k[g]),
         .init_val (INIT_V[g]),
         .q        (q[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap <= 1'b0;
      end else begin
`ifdef JK_SR_COUNTER_SATURATE_EN
         wrap <= 1'b0;
`else
         wrap <= tc;
`endif
      end
   end

endmodule
